qrs_peak_detector: RTL and testbench



---
 rtl/qrs_peak_detector.sv | 119 +++++++++++
 tb/tb_qrs_peak_detector.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/qrs_peak_detector.sv
// rtl/qrs_peak_detector.sv - adaptive-threshold R-peak detector with refractory blanking
// Emits the sample index of each accepted local maximum that clears the running SPK/NPK threshold.
module qrs_peak_detector #(
    parameter int unsigned REFRACTORY = 100,
    parameter int          INIT_SPK   = 800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_axis_tvalid,
    input  logic [31:0] s_axis_tdata,
    output logic        s_axis_tready,
    output logic        m_axis_tvalid,
    output logic [31:0] m_axis_tdata,
    input  logic        m_axis_tready,
    output logic [31:0] threshold
);
    typedef enum logic [1:0] {WARMUP, SEARCH, REFRACT} state_t;

    localparam logic [31:0]        REFR_LOAD = 32'(REFRACTORY);
    localparam logic signed [31:0] SPK_RST   = 32'(INIT_SPK);

    state_t             state_q, state_d;
    logic [31:0]        idx_q, idx_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        mdata_q, mdata_d;
    logic               mvalid_q, mvalid_d;
    logic signed [31:0] x1_q, x1_d, x2_q, x2_d;
    logic signed [31:0] spk_q, spk_d, npk_q, npk_d, thr_q, thr_d;
    logic signed [31:0] x_in;
    logic               accept, local_max;

    // Input is stalled whenever an undelivered event would otherwise be overwritten.
    assign s_axis_tready = ~rst & (~mvalid_q | m_axis_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign x_in          = s_axis_tdata[31] ? 32'sd0 : $signed(s_axis_tdata);
    // Strict rise then non-strict fall: a flat top reports only its first sample.
    assign local_max     = (x2_q < x1_q) && (x1_q >= x_in);

    assign m_axis_tvalid = mvalid_q;
    assign m_axis_tdata  = mdata_q;
    assign threshold     = thr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WARMUP;
            idx_q    <= '0;
            cnt_q    <= '0;
            mdata_q  <= '0;
            mvalid_q <= 1'b0;
            x1_q     <= '0;
            x2_q     <= '0;
            spk_q    <= SPK_RST;
            npk_q    <= '0;
            thr_q    <= SPK_RST >>> 2;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            mdata_q  <= mdata_d;
            mvalid_q <= mvalid_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            spk_q    <= spk_d;
            npk_q    <= npk_d;
            thr_q    <= thr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        mdata_d  = mdata_q;
        mvalid_d = mvalid_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        spk_d    = spk_q;
        npk_d    = npk_q;
        // Built from the registered estimates, so a detection always sees the pre-update threshold.
        thr_d    = npk_q + ((spk_q - npk_q) >>> 2);

        if (m_axis_tready) begin
            mvalid_d = 1'b0;
        end

        if (accept) begin
            idx_d = idx_q + 32'd1;
            x1_d  = x_in;
            x2_d  = x1_q;
            case (state_q)
                WARMUP: begin
                    if (idx_q == 32'd1) begin
                        state_d = SEARCH;
                    end
                end
                SEARCH: begin
                    if (local_max) begin
                        if (x1_q >= thr_q) begin
                            spk_d    = spk_q - (spk_q >>> 3) + (x1_q >>> 3);
                            mdata_d  = idx_q - 32'd1;
                            mvalid_d = 1'b1;
                            cnt_d    = REFR_LOAD;
                            state_d  = REFRACT;
                        end else begin
                            npk_d = npk_q - (npk_q >>> 3) + (x1_q >>> 3);
                        end
                    end
                end
                REFRACT: begin
                    cnt_d = cnt_q - 32'd1;
                    if (cnt_q <= 32'd1) begin
                        state_d = SEARCH;
                    end
                end
                default: state_d = WARMUP;
            endcase
        end
    end
endmodule

// File: tb/tb_qrs_peak_detector.sv
// tb/tb_qrs_peak_detector.sv - bench for qrs_peak_detector
// Directed vector table, hand-written corner sequences and a randomized run against a reference model.
module tb_qrs_peak_detector;
    localparam int REFR = 4;
    localparam int ISPK = 800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tready;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tready = 1'b1;
    logic [31:0] thr;

    qrs_peak_detector #(.REFRACTORY(REFR), .INIT_SPK(ISPK)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tdata  (s_tdata),
        .s_axis_tready (s_tready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tdata  (m_tdata),
        .m_axis_tready (m_tready),
        .threshold     (thr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;

    // Reference model: list of recent accepted samples plus running estimates.
    int          spk_m, npk_m, thr_m, n_m, sig_m;
    logic        mv_m;
    logic [31:0] md_m;
    int          hq[$];

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        mr;
        logic        ev;
        logic [31:0] idx;
        logic [31:0] th;
    } vec_t;
    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        spk_m = ISPK;
        npk_m = 0;
        thr_m = ISPK >>> 2;
        mv_m  = 1'b0;
        md_m  = '0;
        n_m   = 0;
        sig_m = -1000;
        hq.delete();
    endtask

    // One clock: drive at the falling edge, check ready, step model at the rising edge, check outputs.
    task automatic cycle(input logic r, input logic v, input logic [31:0] d, input logic mr);
        logic acc;
        int   old_thr, x, a, b, c;
        rst = r; s_tvalid = v; s_tdata = d; m_tready = mr;
        #1;
        chk1("s_tready", s_tready, !r && (!mv_m || mr));
        if (!r && m_tvalid && m_tready) xfer_cnt++;
        acc = !r && v && (!mv_m || mr);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            old_thr = thr_m;
            thr_m = npk_m + ((spk_m - npk_m) >>> 2);
            if (mv_m && mr) mv_m = 1'b0;
            if (acc) begin
                x = d[31] ? 0 : int'(d);
                hq.push_back(x);
                if (hq.size() > 3) void'(hq.pop_front());
                if (n_m >= 2 && (n_m - sig_m) > REFR) begin
                    a = hq[0]; b = hq[1]; c = hq[2];
                    if (a < b && b >= c) begin
                        if (b >= old_thr) begin
                            spk_m = spk_m - (spk_m >>> 3) + (b >>> 3);
                            mv_m  = 1'b1;
                            md_m  = 32'(n_m - 1);
                            sig_m = n_m;
                        end else begin
                            npk_m = npk_m - (npk_m >>> 3) + (b >>> 3);
                        end
                    end
                end
                n_m++;
            end
        end
        @(negedge clk);
        chk1("m_tvalid", m_tvalid, mv_m);
        chk("m_tdata", m_tdata, md_m);
        chk("threshold", thr, 32'(thr_m));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 32'd0,          1'b1, 1'b0, 32'd0,  32'd200};
        vecs[1]  = '{1'b1, 32'd100,        1'b1, 1'b0, 32'd0,  32'd200};
        vecs[2]  = '{1'b1, 32'd500,        1'b1, 1'b0, 32'd0,  32'd200};
        vecs[3]  = '{1'b1, 32'd300,        1'b1, 1'b1, 32'd2,  32'd200};
        vecs[4]  = '{1'b1, 32'd0,          1'b1, 1'b0, 32'd2,  32'd190};
        vecs[5]  = '{1'b1, 32'd0,          1'b1, 1'b0, 32'd2,  32'd190};
        vecs[6]  = '{1'b1, 32'd600,        1'b1, 1'b0, 32'd2,  32'd190};
        vecs[7]  = '{1'b1, 32'd0,          1'b1, 1'b0, 32'd2,  32'd190};
        vecs[8]  = '{1'b1, 32'd0,          1'b1, 1'b0, 32'd2,  32'd190};
        vecs[9]  = '{1'b1, 32'd150,        1'b1, 1'b0, 32'd2,  32'd190};
        vecs[10] = '{1'b1, 32'd0,          1'b1, 1'b0, 32'd2,  32'd190};
        vecs[11] = '{1'b1, 32'd0,          1'b1, 1'b0, 32'd2,  32'd204};
        vecs[12] = '{1'b1, 32'hFFFF_FE0C,  1'b1, 1'b0, 32'd2,  32'd204};
        vecs[13] = '{1'b1, 32'd300,        1'b1, 1'b0, 32'd2,  32'd204};
        vecs[14] = '{1'b1, 32'd300,        1'b1, 1'b1, 32'd13, 32'd204};
        vecs[15] = '{1'b1, 32'd300,        1'b1, 1'b0, 32'd13, 32'd189};
        vecs[16] = '{1'b1, 32'd0,          1'b1, 1'b0, 32'd13, 32'd189};

        model_reset();
        @(negedge clk);
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        chk1("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_threshold", thr, 32'd200);
        chk1("rst_s_tready", s_tready, 1'b0);
        rst = 1'b0;
        #1;
        chk1("post_rst_s_tready", s_tready, 1'b1);

        for (int i = 0; i < 17; i++) begin
            cycle(1'b0, vecs[i].v, vecs[i].d, vecs[i].mr);
            chk1($sformatf("vec%0d_tvalid", i), m_tvalid, vecs[i].ev);
            chk($sformatf("vec%0d_tdata", i), m_tdata, vecs[i].idx);
            chk($sformatf("vec%0d_threshold", i), thr, vecs[i].th);
        end

        // Backpressure: event on the sample after 900 while downstream is stalled.
        repeat (3) cycle(1'b0, 1'b1, 32'd0, 1'b1);
        cycle(1'b0, 1'b1, 32'd900, 1'b1);
        cycle(1'b0, 1'b1, 32'd0, 1'b0);
        chk1("bp_event_tvalid", m_tvalid, 1'b1);
        chk("bp_event_tdata", m_tdata, 32'd20);
        xfer_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 32'd555, 1'b0);
            chk1("bp_hold_s_tready", s_tready, 1'b0);
            chk1("bp_hold_tvalid", m_tvalid, 1'b1);
            chk("bp_hold_tdata", m_tdata, 32'd20);
        end
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk1("bp_release_tvalid", m_tvalid, 1'b0);
        chk1("bp_release_s_tready", s_tready, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("bp_xfer_count", 32'(xfer_cnt), 32'd1);

        // Stalled 555 samples must not have advanced the index.
        repeat (5) cycle(1'b0, 1'b1, 32'd0, 1'b1);
        cycle(1'b0, 1'b1, 32'd700, 1'b1);
        cycle(1'b0, 1'b1, 32'd0, 1'b1);
        chk1("resume_tvalid", m_tvalid, 1'b1);
        chk("resume_tdata", m_tdata, 32'd27);
        chk("resume_threshold", thr, 32'd195);

        // Reset with the event still pending.
        cycle(1'b1, 1'b0, 32'd0, 1'b0);
        chk1("rst_pending_tvalid", m_tvalid, 1'b0);
        chk("rst_pending_tdata", m_tdata, 32'd0);
        chk("rst_pending_threshold", thr, 32'd200);
        cycle(1'b1, 1'b0, 32'd0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            logic        r, v, mr;
            logic [31:0] d;
            r  = ($urandom_range(0, 499) == 0);
            v  = ($urandom_range(0, 9) < 8);
            mr = ($urandom_range(0, 9) < 7);
            d  = 32'($urandom_range(0, 1400)) - 32'd300;
            cycle(r, v, d, mr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
